// File: rtl/ct_ciu_vb_sched_pkg.sv
// Shared CIU victim-buffer definitions: entry/id/beat sizing, AW FSM states and
// one-hot/index helpers used by the scheduler and its arbiter.
package ct_ciu_vb_sched_pkg;

    localparam int VB_ENTRY_NUM = 4;
    localparam int VB_ID_W      = 2;
    localparam int VB_WBEAT_NUM = 4;
    localparam int VB_BEAT_W    = 2;
    localparam int VB_CNT_W     = VB_ID_W + 1;

    localparam logic [VB_BEAT_W-1:0] VB_WBEAT_LAST = VB_BEAT_W'(VB_WBEAT_NUM - 1);
    localparam logic [VB_CNT_W-1:0]  VB_FIFO_DEPTH = VB_CNT_W'(VB_ENTRY_NUM);

    typedef logic [VB_ENTRY_NUM-1:0] vb_vec_t;
    typedef logic [VB_ID_W-1:0]      vb_id_t;

    typedef enum logic {
        AW_IDLE = 1'b0,
        AW_LOCK = 1'b1
    } vb_aw_state_t;

    function automatic vb_vec_t vb_id2sel(input vb_id_t id);
        vb_vec_t sel;
        sel     = '0;
        sel[id] = 1'b1;
        return sel;
    endfunction

    function automatic vb_id_t vb_sel2id(input vb_vec_t sel);
        vb_id_t id;
        id = '0;
        for (int i = 0; i < VB_ENTRY_NUM; i++) begin
            if (sel[i]) id = vb_id_t'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/ct_ciu_vb_aw_arb.sv
// Victim-buffer AW arbiter: one-hot grant to the first requester found after
// ptr, wrapping around. A pointer of the last index gives fixed lowest-first priority.
module ct_ciu_vb_aw_arb
    import ct_ciu_vb_sched_pkg::*;
(
    input  logic [VB_ENTRY_NUM-1:0] req,
    input  logic [VB_ID_W-1:0]      ptr,
    output logic [VB_ENTRY_NUM-1:0] gnt
);

    vb_id_t idx;

    // Scan farthest-first so the candidate closest after ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = VB_ENTRY_NUM; k >= 1; k--) begin
            idx = ptr + vb_id_t'(k);
            if (req[idx]) gnt = vb_id2sel(idx);
        end
    end

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate: the enable is captured while the clock is low so the
// gated clock never glitches.
module gated_clk_cell (
    input  logic clk_in,
    input  logic local_en,
    output logic clk_out
);

    logic en_lat;

    always_latch begin
        if (!clk_in) en_lat <= local_en;
    end

    assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/ct_ciu_vb_sched.sv
// Victim-buffer scheduler: entry allocation, AW arbitration with AXI id lock,
// AW-order FIFO and W beat sequencing. CT_CIU_VB_RR_ARB_EN selects round-robin AW arbitration.
module ct_ciu_vb_sched
    import ct_ciu_vb_sched_pkg::*;
(
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    vb_create_req,
    output logic                    vb_create_gnt,
    output logic [VB_ENTRY_NUM-1:0] vb_aw_create_sel,
    input  logic [VB_ENTRY_NUM-1:0] vb_aw_vld,
    input  logic [VB_ENTRY_NUM-1:0] vb_aw_en,
    input  logic [VB_ENTRY_NUM-1:0] vb_w_vld,
    output logic [VB_ENTRY_NUM-1:0] vb_aw_req_sel,
    output logic                    vb_awvalid,
    input  logic                    vb_awready,
    output logic [VB_ID_W-1:0]      vb_aw_id,
    output logic                    vb_wvalid,
    input  logic                    vb_wready,
    output logic                    vb_wlast,
    output logic [VB_ID_W-1:0]      vb_w_id,
    output logic [VB_BEAT_W-1:0]    vb_w_beat,
    output logic [VB_ENTRY_NUM-1:0] vb_w_pop_sel,
    output logic                    vb_full,
    output logic                    vb_empty
);

    vb_vec_t           free_vec;
    vb_vec_t           create_pick;
    vb_aw_state_t      aw_state;
    vb_id_t            aw_lock_id;
    vb_id_t            aw_arb_id;
    vb_id_t            arb_ptr;
    vb_vec_t           aw_arb_gnt;
    logic              aw_locked;
    logic              aw_hs;
    logic              w_hs;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    vb_id_t            fifo_head;
    vb_id_t            fifo_mem [VB_ENTRY_NUM];
    vb_id_t            fifo_wr_ptr;
    vb_id_t            fifo_rd_ptr;
    logic [VB_CNT_W-1:0]  fifo_cnt;
    logic [VB_BEAT_W-1:0] w_beat_cnt;
    logic              vb_ctrl_clk;
    logic              ctrl_clk_en;

    assign free_vec         = ~vb_aw_vld;
    assign create_pick      = free_vec & (-free_vec);
    assign vb_full          = &vb_aw_vld;
    assign vb_empty         = ~|vb_aw_vld;
    assign vb_create_gnt    = vb_create_req & ~vb_full;
    assign vb_aw_create_sel = vb_create_gnt ? create_pick : '0;

`ifdef CT_CIU_VB_RR_ARB_EN
    vb_id_t rr_ptr;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rr_ptr <= '0;
        end else if (aw_hs) begin
            rr_ptr <= vb_aw_id;
        end
    end

    assign arb_ptr = rr_ptr;
`else
    assign arb_ptr = vb_id_t'(VB_ENTRY_NUM - 1);
`endif

    ct_ciu_vb_aw_arb x_ct_ciu_vb_aw_arb (
        .req (vb_aw_en),
        .ptr (arb_ptr),
        .gnt (aw_arb_gnt)
    );

    assign aw_arb_id     = vb_sel2id(aw_arb_gnt);
    assign aw_locked     = (aw_state == AW_LOCK);
    assign vb_awvalid    = aw_locked | (|vb_aw_en);
    assign vb_aw_id      = aw_locked ? aw_lock_id : aw_arb_id;
    assign aw_hs         = vb_awvalid & vb_awready;
    assign vb_aw_req_sel = aw_hs ? vb_id2sel(vb_aw_id) : '0;

    // Once AW is presented without ready, the id is frozen until the handshake.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            aw_state   <= AW_IDLE;
            aw_lock_id <= '0;
        end else begin
            case (aw_state)
                AW_IDLE: begin
                    if (vb_awvalid && !vb_awready) begin
                        aw_state   <= AW_LOCK;
                        aw_lock_id <= aw_arb_id;
                    end
                end
                AW_LOCK: begin
                    if (vb_awready) aw_state <= AW_IDLE;
                end
                default: aw_state <= AW_IDLE;
            endcase
        end
    end

    assign fifo_empty   = (fifo_cnt == '0);
    assign fifo_head    = fifo_mem[fifo_rd_ptr];
    assign vb_wvalid    = ~fifo_empty & vb_w_vld[fifo_head];
    assign vb_w_id      = fifo_head;
    assign vb_w_beat    = w_beat_cnt;
    assign vb_wlast     = (w_beat_cnt == VB_WBEAT_LAST);
    assign w_hs         = vb_wvalid & vb_wready;
    assign fifo_push    = aw_hs;
    assign fifo_pop     = w_hs & vb_wlast;
    assign vb_w_pop_sel = fifo_pop ? vb_id2sel(fifo_head) : '0;

    assign ctrl_clk_en = aw_hs | w_hs | vb_create_req;

    gated_clk_cell x_vb_ctrl_gated_clk (
        .clk_in   (forever_cpuclk),
        .local_en (ctrl_clk_en),
        .clk_out  (vb_ctrl_clk)
    );

    // AW-order FIFO and beat counter; their state only moves on a handshake.
    always_ff @(posedge vb_ctrl_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < VB_ENTRY_NUM; i++) fifo_mem[i] <= '0;
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_cnt    <= '0;
            w_beat_cnt  <= '0;
        end else begin
            if (fifo_push) begin
                fifo_mem[fifo_wr_ptr] <= vb_aw_id;
                fifo_wr_ptr           <= fifo_wr_ptr + 2'd1;
            end
            if (fifo_pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + 2'd1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (w_hs) begin
                w_beat_cnt <= w_beat_cnt + 2'd1;
            end
        end
    end

    a_vb_fifo_no_overflow: assert property (
        @(posedge forever_cpuclk) disable iff (!cpurst_b)
        !(aw_hs && fifo_cnt == VB_FIFO_DEPTH)
    );

endmodule

// File: doc/ct_ciu_vb_sched.md
CT_CIU_VB_SCHED -- requirements
Module: ct_ciu_vb_sched

Interface
- REQ-001: Clock and reset SHALL be: one clock, forever_cpuclk; reset cpurst_b is asynchronous and active-low.
- REQ-002: forever_cpuclk  in  1  sole clock, rising edge.
- REQ-003: cpurst_b  in  1  asynchronous active-low reset.
- REQ-004: vb_create_req  in  1  request to allocate a victim-buffer entry.
- REQ-005: vb_create_gnt  out  1  allocation granted this cycle.
- REQ-006: vb_aw_create_sel  out  4  one-hot entry being allocated.
- REQ-007: vb_aw_vld / vb_aw_en / vb_w_vld  in  4 each  per-entry valid, AW-pending and data-valid status.
- REQ-008: vb_aw_req_sel  out  4  one-hot pulse: the entry's AW was accepted.
- REQ-009: vb_awvalid  out  1 / vb_awready  in  1 / vb_aw_id  out  2  AXI AW handshake and selected entry.
- REQ-010: vb_wvalid  out  1 / vb_wready  in  1 / vb_wlast  out  1 / vb_w_id  out  2 / vb_w_beat  out  2  AXI W handshake, entry and beat index.
- REQ-011: vb_w_pop_sel  out  4  one-hot pulse: the entry is retired.
- REQ-012: vb_full / vb_empty  out  1 each  no free entry / no valid entry.

Function
- REQ-013: Free entry = vb_aw_vld[i]==0. vb_create_gnt = vb_create_req & ~vb_full. vb_aw_create_sel = lowest-index free entry gated by the grant; both are combinational, zero latency.
- REQ-014: vb_full = &vb_aw_vld; vb_empty = ~|vb_aw_vld.
- REQ-015: AW candidates = vb_aw_en. vb_awvalid = lock | (|vb_aw_en).
- REQ-016: The AW state machine SHALL be IDLE->LOCK.
  - Moves to LOCK when awvalid & ~awready; the chosen id is registered.
  - Returns to IDLE on the awready handshake.
  - While in LOCK, vb_aw_id SHALL NOT change (AXI stability).
- REQ-017: On the AW handshake, vb_aw_req_sel[vb_aw_id] pulses for exactly that cycle, and vb_aw_id is pushed into a 4-deep 2-bit order FIFO.
- REQ-018: W channel always serves the FIFO head.
  - vb_wvalid = ~fifo_empty & vb_w_vld[head].
  - vb_w_id = head.
- REQ-019: W beat counter:
  - 2-bit, reset 0, increments on each W handshake.
  - vb_w_beat = counter.
  - vb_wlast = (counter==3).
  - Wraps to 0 after the last beat.
- REQ-020: On a W handshake with wlast, vb_w_pop_sel[head] pulses that cycle and the FIFO pops.
- REQ-021: Simultaneous FIFO push and pop SHALL both take effect; the occupancy count is unchanged.
- REQ-022: The FIFO cannot overflow because there are at most 4 entries. An AW handshake while the FIFO holds 4 entries is an assertion failure.
- REQ-023: Create and pop on the same entry in the same cycle cannot occur, because a popped entry still has vb_aw_vld=1. Create and pop on different entries SHALL both proceed.
- REQ-024: Without CT_CIU_VB_RR_ARB_EN, AW selection in IDLE is fixed priority, lowest index first.

Reset
- REQ-025: On reset:
  - AW state = IDLE; locked id = 0.
  - FIFO pointers and count = 0; beat counter = 0; RR pointer = 0.
  - All outputs 0 with vb_empty=1 (inputs at reset values).
- REQ-026: Reset mid-burst SHALL discard the FIFO contents and the beat count immediately; no pop pulse is generated.

Configuration
- REQ-027: Macro CT_CIU_VB_RR_ARB_EN.
  - Defined: AW selection is round-robin. The search starts at rr_ptr+1, and rr_ptr takes the granted id on each AW handshake.
  - Undefined: fixed priority per REQ-024; the rr_ptr register is absent.

Structure
- REQ-028: Constants VB_ENTRY_NUM=4, VB_ID_W=2 and VB_WBEAT_NUM=4 SHALL live in the shared CIU VB define package/include.
- REQ-029: Arbitration SHALL be one sub-module, ct_ciu_vb_aw_arb: request vector plus pointer in, one-hot grant out.
- REQ-030: All state SHALL sit on forever_cpuclk; the FIFO and counters sit behind one gated_clk_cell instance whose local_en = any handshake or create.

Verification
- REQ-031: vb_aw_vld=4'b0101, create_req=1 -> gnt=1, create_sel=4'b0010.
- REQ-032: vb_aw_vld=4'b1111, create_req=1 -> gnt=0, create_sel=0, full=1.
- REQ-033: aw_en=4'b0100, awready low for 3 cycles, then aw_en[1] rises -> aw_id holds 2 until the handshake; req_sel=4'b0100 pulses once.
- REQ-034: AW order entries 3 then 0, both w_vld=1, wready=1 -> 8 W beats; beats 0..3 with wlast on beat 3 for entry 3, then entry 0; pop_sel=4'b1000, then 4'b0001.
- REQ-035: RR enabled, aw_en=4'b1111, awready=1 constantly -> grant order 1,2,3,0; RR disabled -> 0,1,2,3.
- REQ-036: Assert cpurst_b low after W beat 2 of an entry -> next cycle wvalid=0, beat=0, no pop_sel pulse.
